// File: rtl/rasterizer_pkg.sv
// Shared definitions for the fragment depth writer.
// Holds the Q16.16 fragment format, the writer FSM state encoding and the
// clamp helper used when turning signed fixed-point attributes into unsigned
// buffer values.
package rasterizer_pkg;

  localparam int INT_BITS   = 16;
  localparam int FRAC_BITS  = 16;
  localparam int DATA_WIDTH = INT_BITS + FRAC_BITS;

  typedef logic [DATA_WIDTH-1:0] fixed_t;
  typedef logic [FRAC_BITS-1:0]  frac_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fdw_state_e;

  // Clamp a signed Q16.16 value into [0, 1.0) as a full-precision fraction:
  // negatives become 0, anything at or above 1.0 saturates to all ones.
  // Callers keep the top bits they need.
  function automatic frac_t quantise_clamp(input fixed_t value);
    frac_t result;
    if (value[DATA_WIDTH-1]) begin
      result = {FRAC_BITS{1'b0}};
    end else if (|value[DATA_WIDTH-2:FRAC_BITS]) begin
      result = {FRAC_BITS{1'b1}};
    end else begin
      result = value[FRAC_BITS-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/fragment_quantize.sv
// Combinational fragment quantiser.
// Floors the Q16.16 pixel coordinates, flags fragments that fall outside the
// screen, forms the linear buffer address and clamps depth and colour.
// Ports:
//   x, y      in  signed Q16.16 pixel coordinates
//   attr      in  N_ATTR packed Q16.16 attributes, [0]=depth, [1..3]=R,G,B
//   offscreen out fragment lies outside the screen
//   addr      out py*SCREEN_WIDTH+px (meaningful only when on screen)
//   depth     out clamped depth, DEPTH_BITS wide
//   color     out clamped {R,G,B}, COLOR_BITS per channel
module fragment_quantize
  import rasterizer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 360,
  parameter int DEPTH_BITS    = 16,
  parameter int COLOR_BITS    = 4,
  parameter int N_ATTR        = 4,
  parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic [DATA_WIDTH-1:0]        x,
  input  logic [DATA_WIDTH-1:0]        y,
  input  logic [N_ATTR*DATA_WIDTH-1:0] attr,
  output logic                         offscreen,
  output logic [ADDR_WIDTH-1:0]        addr,
  output logic [DEPTH_BITS-1:0]        depth,
  output logic [3*COLOR_BITS-1:0]      color
);

  // Arithmetic shift then floor is the same as taking the integer field;
  // the sign bit alone decides px<0 / py<0.
  logic [31:0] px_s;
  logic [31:0] py_s;
  logic        unused_frac_s;

  assign px_s = 32'(x[DATA_WIDTH-2:FRAC_BITS]);
  assign py_s = 32'(y[DATA_WIDTH-2:FRAC_BITS]);

  // Sub-pixel position does not affect which pixel is written.
  assign unused_frac_s = ^{x[FRAC_BITS-1:0], y[FRAC_BITS-1:0]};

  assign offscreen = x[DATA_WIDTH-1] | y[DATA_WIDTH-1]
                   | (px_s >= 32'(SCREEN_WIDTH))
                   | (py_s >= 32'(SCREEN_HEIGHT));

  assign addr = ADDR_WIDTH'(py_s * 32'(SCREEN_WIDTH) + px_s);

  // Depth and channels keep the most significant fraction bits.
  assign depth = DEPTH_BITS'(quantise_clamp(attr[0*DATA_WIDTH +: DATA_WIDTH])
                             >> (FRAC_BITS - DEPTH_BITS));
  assign color = {
    COLOR_BITS'(quantise_clamp(attr[1*DATA_WIDTH +: DATA_WIDTH]) >> (FRAC_BITS - COLOR_BITS)),
    COLOR_BITS'(quantise_clamp(attr[2*DATA_WIDTH +: DATA_WIDTH]) >> (FRAC_BITS - COLOR_BITS)),
    COLOR_BITS'(quantise_clamp(attr[3*DATA_WIDTH +: DATA_WIDTH]) >> (FRAC_BITS - COLOR_BITS))
  };

endmodule

// File: rtl/fragment_depth_writer.sv
// Fragment depth writer: tail of the rasterizer fragment stream.
// Accepts one fragment per cycle while running, depth-tests it against the
// depth buffer (1-cycle read, port A) and commits passing fragments to the
// depth buffer (port B) and the framebuffer two cycles after acceptance.
// Clears both buffers after reset and on request.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   i_fragment_x/_y/_attr           Q16.16 fragment (attr[0]=depth, [1..3]=RGB)
//   i_dv / o_ready                  fragment handshake
//   i_clear                         full-clear request pulse
//   o_zb_rd_en/_rd_addr, i_zb_rdata depth buffer read port
//   o_zb_we/_wr_addr/_wdata         depth buffer write port
//   o_fb_we/_addr/_wdata            framebuffer write port
//   o_busy                          clearing or draining
//   o_n_written, o_n_rejected       commit / reject counters
module fragment_depth_writer
  import rasterizer_pkg::*;
#(
  parameter int                    SCREEN_WIDTH  = 640,
  parameter int                    SCREEN_HEIGHT = 360,
  parameter int                    DEPTH_BITS    = 16,
  parameter int                    COLOR_BITS    = 4,
  parameter int                    N_ATTR        = 4,
  parameter int                    ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter logic [3*COLOR_BITS-1:0] CLEAR_COLOR = {(3*COLOR_BITS){1'b0}}
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_WIDTH-1:0]        i_fragment_x,
  input  logic [DATA_WIDTH-1:0]        i_fragment_y,
  input  logic [N_ATTR*DATA_WIDTH-1:0] i_fragment_attr,
  input  logic                         i_dv,
  output logic                         o_ready,
  input  logic                         i_clear,
  output logic [ADDR_WIDTH-1:0]        o_zb_rd_addr,
  output logic                         o_zb_rd_en,
  input  logic [DEPTH_BITS-1:0]        i_zb_rdata,
  output logic                         o_zb_we,
  output logic [ADDR_WIDTH-1:0]        o_zb_wr_addr,
  output logic [DEPTH_BITS-1:0]        o_zb_wdata,
  output logic                         o_fb_we,
  output logic [ADDR_WIDTH-1:0]        o_fb_addr,
  output logic [3*COLOR_BITS-1:0]      o_fb_wdata,
  output logic                         o_busy,
  output logic [31:0]                  o_n_written,
  output logic [31:0]                  o_n_rejected
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

  fdw_state_e state_r, state_next_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;

  // S0 (accept cycle)
  logic                    accept_s;
  logic                    q_off_s;
  logic [ADDR_WIDTH-1:0]   q_addr_s;
  logic [DEPTH_BITS-1:0]   q_depth_s;
  logic [3*COLOR_BITS-1:0] q_color_s;

  // S1 (compare cycle)
  logic                    s1_valid_r;
  logic                    s1_off_r;
  logic [ADDR_WIDTH-1:0]   s1_addr_r;
  logic [DEPTH_BITS-1:0]   s1_depth_r;
  logic [3*COLOR_BITS-1:0] s1_color_r;
  logic [DEPTH_BITS-1:0]   stored_depth_s;
  logic                    pass_s;

  // S2 (write cycle): these registers drive both memory write ports
  logic                    s2_valid_r;
  logic                    wr_we_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [DEPTH_BITS-1:0]   wr_depth_r;
  logic [3*COLOR_BITS-1:0] wr_color_r;

  // Depth write issued one cycle earlier; the RAM read launched in that same
  // cycle returned the pre-write value, so it must be forwarded.
  logic                    prev_we_r;
  logic [ADDR_WIDTH-1:0]   prev_addr_r;
  logic [DEPTH_BITS-1:0]   prev_depth_r;

  logic [31:0] written_r;
  logic [31:0] rejected_r;

  fragment_quantize #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .DEPTH_BITS    (DEPTH_BITS),
    .COLOR_BITS    (COLOR_BITS),
    .N_ATTR        (N_ATTR),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_quantize (
    .x         (i_fragment_x),
    .y         (i_fragment_y),
    .attr      (i_fragment_attr),
    .offscreen (q_off_s),
    .addr      (q_addr_s),
    .depth     (q_depth_s),
    .color     (q_color_s)
  );

  // Handshake and read request are combinational so the read lands in S1.
  assign o_ready      = (state_r == ST_RUN);
  assign o_busy       = (state_r == ST_CLEAR) | (state_r == ST_DRAIN);
  assign accept_s     = i_dv & o_ready;
  assign o_zb_rd_en   = accept_s & ~q_off_s;
  assign o_zb_rd_addr = q_addr_s;

  assign o_zb_we      = wr_we_r;
  assign o_zb_wr_addr = wr_addr_r;
  assign o_zb_wdata   = wr_depth_r;
  assign o_fb_we      = wr_we_r;
  assign o_fb_addr    = wr_addr_r;
  assign o_fb_wdata   = wr_color_r;
  assign o_n_written  = written_r;
  assign o_n_rejected = rejected_r;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: clear sweeps, run accepts, drain waits for S1/S2 to empty
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (i_clear) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_r && !s2_valid_r) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_CLEAR;
    endcase
  end

  // Clear address counter, held at zero outside the clear sweep
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (state_r == ST_CLEAR && clr_cnt_r != LAST_ADDR) begin
      clr_cnt_r <= clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end
  end

  // S1 capture of the accepted, quantised fragment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_off_r   <= 1'b0;
      s1_addr_r  <= {ADDR_WIDTH{1'b0}};
      s1_depth_r <= {DEPTH_BITS{1'b0}};
      s1_color_r <= {(3*COLOR_BITS){1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_off_r   <= q_off_s;
        s1_addr_r  <= q_addr_s;
        s1_depth_r <= q_depth_s;
        s1_color_r <= q_color_s;
      end else begin
        s1_off_r   <= s1_off_r;
        s1_addr_r  <= s1_addr_r;
        s1_depth_r <= s1_depth_r;
        s1_color_r <= s1_color_r;
      end
    end
  end

  // Stored-depth forwarding (youngest write wins) and strict-less depth test
  always_comb begin
    stored_depth_s = i_zb_rdata;
    if (wr_we_r && (wr_addr_r == s1_addr_r)) begin
      stored_depth_s = wr_depth_r;
    end else if (prev_we_r && (prev_addr_r == s1_addr_r)) begin
      stored_depth_s = prev_depth_r;
    end else begin
      stored_depth_s = i_zb_rdata;
    end
    pass_s = s1_valid_r & ~s1_off_r & (s1_depth_r < stored_depth_s);
  end

  // Write-port registers: clear sweep or S2 commit of a passing fragment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_r <= 1'b0;
      wr_we_r    <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_depth_r <= {DEPTH_BITS{1'b0}};
      wr_color_r <= {(3*COLOR_BITS){1'b0}};
    end else if (state_r == ST_CLEAR) begin
      s2_valid_r <= 1'b0;
      wr_we_r    <= 1'b1;
      wr_addr_r  <= clr_cnt_r;
      wr_depth_r <= {DEPTH_BITS{1'b1}};
      wr_color_r <= CLEAR_COLOR;
    end else begin
      s2_valid_r <= s1_valid_r;
      wr_we_r    <= pass_s;
      wr_addr_r  <= s1_addr_r;
      wr_depth_r <= s1_depth_r;
      wr_color_r <= s1_color_r;
    end
  end

  // One-cycle-old copy of the depth write for read-during-write forwarding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_we_r    <= 1'b0;
      prev_addr_r  <= {ADDR_WIDTH{1'b0}};
      prev_depth_r <= {DEPTH_BITS{1'b0}};
    end else begin
      prev_we_r    <= wr_we_r;
      prev_addr_r  <= wr_addr_r;
      prev_depth_r <= wr_depth_r;
    end
  end

  // Commit/reject counters, zeroed when a clear sweep begins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      written_r  <= 32'd0;
      rejected_r <= 32'd0;
    end else if (state_r == ST_DRAIN && state_next_s == ST_CLEAR) begin
      written_r  <= 32'd0;
      rejected_r <= 32'd0;
    end else if (s1_valid_r) begin
      if (pass_s) begin
        written_r  <= written_r + 32'd1;
        rejected_r <= rejected_r;
      end else begin
        written_r  <= written_r;
        rejected_r <= rejected_r + 32'd1;
      end
    end else begin
      written_r  <= written_r;
      rejected_r <= rejected_r;
    end
  end

endmodule

// File: tb/tb_fragment_depth_writer.sv
// Directed bench for fragment_depth_writer on an 8x4 screen.
// The bench owns a depth/frame memory model and compares buffer contents,
// counters and timing against hand-computed values.
module tb_fragment_depth_writer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int AW = 5;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  i_fragment_x;
  logic [31:0]  i_fragment_y;
  logic [127:0] i_fragment_attr;
  logic         i_dv;
  logic         o_ready;
  logic         i_clear;
  logic [AW-1:0] o_zb_rd_addr;
  logic         o_zb_rd_en;
  logic [15:0]  zb_rdata;
  logic         o_zb_we;
  logic [AW-1:0] o_zb_wr_addr;
  logic [15:0]  o_zb_wdata;
  logic         o_fb_we;
  logic [AW-1:0] o_fb_addr;
  logic [11:0]  o_fb_wdata;
  logic         o_busy;
  logic [31:0]  o_n_written;
  logic [31:0]  o_n_rejected;

  logic [15:0] zmem [0:W*H-1];
  logic [11:0] fmem [0:W*H-1];
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int last_wr_cyc = 0;

  int tests_run = 0;
  int tests_failed = 0;

  fragment_depth_writer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .DEPTH_BITS    (16),
    .COLOR_BITS    (4)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_fragment_x    (i_fragment_x),
    .i_fragment_y    (i_fragment_y),
    .i_fragment_attr (i_fragment_attr),
    .i_dv            (i_dv),
    .o_ready         (o_ready),
    .i_clear         (i_clear),
    .o_zb_rd_addr    (o_zb_rd_addr),
    .o_zb_rd_en      (o_zb_rd_en),
    .i_zb_rdata      (zb_rdata),
    .o_zb_we         (o_zb_we),
    .o_zb_wr_addr    (o_zb_wr_addr),
    .o_zb_wdata      (o_zb_wdata),
    .o_fb_we         (o_fb_we),
    .o_fb_addr       (o_fb_addr),
    .o_fb_wdata      (o_fb_wdata),
    .o_busy          (o_busy),
    .o_n_written     (o_n_written),
    .o_n_rejected    (o_n_rejected)
  );

  always #5 clk = ~clk;

  // Memory model: read-before-write dual-port depth RAM plus framebuffer
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      for (int i = 0; i < W*H; i++) begin
        zmem[i] <= 16'h0000;
        fmem[i] <= 12'hABC;
      end
      zb_rdata <= 16'h0000;
    end else begin
      if (o_zb_rd_en) begin
        zb_rdata <= zmem[o_zb_rd_addr];
        rd_cnt   <= rd_cnt + 1;
      end
      if (o_zb_we) begin
        zmem[o_zb_wr_addr] <= o_zb_wdata;
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc + 1;
      end
      if (o_fb_we) fmem[o_fb_addr] <= o_fb_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_dv = 1'b0;
    i_clear = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_frag(input logic [31:0] x, input logic [31:0] y, input logic [31:0] d,
                          input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    i_fragment_x = x;
    i_fragment_y = y;
    i_fragment_attr = {b, g, r, d};
    i_dv = 1'b1;
  endtask

  task automatic wait_ready(input int max_cyc, output int n);
    n = 0;
    while (!o_ready && n < max_cyc) begin
      tick();
      n++;
    end
  endtask

  int n;
  int base_wr;
  int base_rd;
  int acc_cyc;
  int bad;

  initial begin
    rstn = 1'b0;
    i_dv = 1'b0;
    i_clear = 1'b0;
    i_fragment_x = 32'h0;
    i_fragment_y = 32'h0;
    i_fragment_attr = 128'h0;
    repeat (3) tick();
    check_eq("rst_zb_we", {31'd0, o_zb_we}, 32'd0);
    check_eq("rst_fb_we", {31'd0, o_fb_we}, 32'd0);
    check_eq("rst_rd_en", {31'd0, o_zb_rd_en}, 32'd0);
    check_eq("rst_ready", {31'd0, o_ready}, 32'd0);
    check_eq("rst_written", o_n_written, 32'd0);
    check_eq("rst_rejected", o_n_rejected, 32'd0);

    // Initial clear sweep
    base_wr = wr_cnt;
    rstn = 1'b1;
    wait_ready(100, n);
    check_eq("clear_ready_lat", n, 32'd32);
    tick();
    check_eq("clear_writes", wr_cnt - base_wr, 32'd32);
    bad = 0;
    for (int i = 0; i < W*H; i++) if (zmem[i] !== 16'hFFFF || fmem[i] !== 12'h000) bad++;
    check_eq("clear_contents", bad, 32'd0);
    check_eq("clear_busy_low", {31'd0, o_busy}, 32'd0);

    // Basic commit at (2,1): depth 0.5, RGB 1.0/0.5/0
    base_wr = wr_cnt;
    set_frag(32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0000_8000, 32'h0);
    tick();
    acc_cyc = cyc;
    idle(4);
    check_eq("t1_zb", zmem[10], 32'h8000);
    check_eq("t1_fb", fmem[10], 32'hF80);
    check_eq("t1_latency", last_wr_cyc - acc_cyc, 32'd2);
    check_eq("t1_nwrites", wr_cnt - base_wr, 32'd1);
    check_eq("t1_written", o_n_written, 32'd1);
    check_eq("t1_rejected", o_n_rejected, 32'd0);

    // Same pixel (3,2) back-to-back: 0.25 passes, 0.75 loses
    set_frag(32'h0003_0000, 32'h0002_0000, 32'h0000_4000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000);
    tick();
    set_frag(32'h0003_0000, 32'h0002_0000, 32'h0000_C000, 32'h0000_C000, 32'h0000_C000, 32'h0000_C000);
    tick();
    idle(4);
    check_eq("t2_zb", zmem[19], 32'h4000);
    check_eq("t2_fb", fmem[19], 32'h123);
    check_eq("t2_written", o_n_written, 32'd2);
    check_eq("t2_rejected", o_n_rejected, 32'd1);

    // Three to addr 5: 0.6, 0.4 (colour clamps), 0.5
    set_frag(32'h0005_0000, 32'h0, 32'h0000_9999, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    tick();
    set_frag(32'h0005_0000, 32'h0, 32'h0000_6666, 32'hFFFF_8000, 32'h0002_0000, 32'h0000_8000);
    tick();
    set_frag(32'h0005_0000, 32'h0, 32'h0000_8000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000);
    tick();
    idle(4);
    check_eq("t3_zb", zmem[5], 32'h6666);
    check_eq("t3_fb", fmem[5], 32'h0F8);
    check_eq("t3_written", o_n_written, 32'd4);
    check_eq("t3_rejected", o_n_rejected, 32'd2);

    // Off-screen x=-1.0 and x=8.0
    base_wr = wr_cnt;
    base_rd = rd_cnt;
    set_frag(32'hFFFF_0000, 32'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h0);
    tick();
    set_frag(32'h0008_0000, 32'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h0);
    tick();
    idle(4);
    check_eq("t4_nreads", rd_cnt - base_rd, 32'd0);
    check_eq("t4_nwrites", wr_cnt - base_wr, 32'd0);
    check_eq("t4_rejected", o_n_rejected, 32'd4);

    // Tie: depth 1.0 saturates to FFFF, equal to cleared value, rejected
    set_frag(32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
    tick();
    idle(4);
    check_eq("tie_zb", zmem[0], 32'hFFFF);
    check_eq("tie_rejected", o_n_rejected, 32'd5);

    // Floor of (7.75,3.5) -> addr 31, tiny depth keeps the low bit
    set_frag(32'h0007_C000, 32'h0003_8000, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
    tick();
    idle(4);
    check_eq("floor_zb", zmem[31], 32'h0001);
    check_eq("floor_written", o_n_written, 32'd5);

    // Write one cycle older than the read: addr5 0.3, addr6 0.5, addr5 0.35
    set_frag(32'h0005_0000, 32'h0, 32'h0000_4CCC, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000);
    tick();
    set_frag(32'h0006_0000, 32'h0, 32'h0000_8000, 32'h0, 32'h0, 32'h0);
    tick();
    set_frag(32'h0005_0000, 32'h0, 32'h0000_5999, 32'h0, 32'h0, 32'h0);
    tick();
    idle(4);
    check_eq("fwd_zb5", zmem[5], 32'h4CCC);
    check_eq("fwd_fb5", fmem[5], 32'h111);
    check_eq("fwd_zb6", zmem[6], 32'h8000);
    check_eq("fwd_rejected", o_n_rejected, 32'd6);

    // Clear request with two fragments in flight
    base_wr = wr_cnt;
    set_frag(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0, 32'h0);
    tick();
    set_frag(32'h0002_0000, 32'h0001_0000, 32'h0000_4000, 32'h0, 32'h0, 32'h0);
    i_clear = 1'b1;
    tick();
    i_dv = 1'b0;
    i_clear = 1'b0;
    check_eq("drain_busy", {31'd0, o_busy}, 32'd1);
    check_eq("drain_ready", {31'd0, o_ready}, 32'd0);
    tick();
    tick();
    check_eq("drain_written", o_n_written, 32'd9);
    wait_ready(100, n);
    check_eq("clr2_timeout", {31'd0, o_ready}, 32'd1);
    tick();
    check_eq("clr2_nwrites", wr_cnt - base_wr, 32'd34);
    check_eq("clr2_written", o_n_written, 32'd0);
    check_eq("clr2_rejected", o_n_rejected, 32'd0);
    bad = 0;
    for (int i = 0; i < W*H; i++) if (zmem[i] !== 16'hFFFF || fmem[i] !== 12'h000) bad++;
    check_eq("clr2_contents", bad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
